// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl
// Game-side controller paired with the bird physics block. One update per
// frame_clk edge (vertical sync). Holds the IDLE/PLAY/DEAD game FSM, two
// scrolling pipe obstacles with pseudo-random gap heights, collision
// detection against the bird square, and a saturating score.
//
// Ports:
//   Reset      in   async active-high reset
//   frame_clk  in   one rising edge per frame
//   space      in   level of the flap/start key
//   BirdX      in   bird left edge
//   BirdY      in   bird top edge (bit 9 set = wrapped above the screen)
//   BirdS      in   bird square size
//   gameOn     out  high only in PLAY
//   ded        out  high only in DEAD
//   PipeX0/1   out  pipe left edges
//   GapY0/1    out  gap top Y of each pipe
//   Score      out  pipes passed, saturating at 255
module flappy_game_ctrl #(
  parameter int unsigned SCREEN_W     = 640,
  parameter int unsigned PIPE_W       = 32,
  parameter int unsigned PIPE_STEP    = 2,
  parameter int unsigned PIPE_SPACING = 320,
  parameter int unsigned GAP_H        = 120,
  parameter int unsigned GAP_MIN      = 96,
  parameter int unsigned GROUND_Y     = 478,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       space,
  input  logic [9:0] BirdX,
  input  logic [9:0] BirdY,
  input  logic [9:0] BirdS,
  output logic       gameOn,
  output logic       ded,
  output logic [9:0] PipeX0,
  output logic [9:0] PipeX1,
  output logic [9:0] GapY0,
  output logic [9:0] GapY1,
  output logic [7:0] Score
);

  localparam logic [9:0]  PipeX0Rst = 10'(SCREEN_W);
  localparam logic [9:0]  PipeX1Rst = 10'(SCREEN_W + PIPE_SPACING);
  localparam logic [9:0]  GapRst    = 10'd160;
  localparam logic [9:0]  StepW     = 10'(PIPE_STEP);
  localparam logic [10:0] PipeWW    = 11'(PIPE_W);
  localparam logic [10:0] GapHW     = 11'(GAP_H);
  localparam logic [10:0] GroundW   = 11'(GROUND_Y);
  localparam logic [9:0]  GapMinW   = 10'(GAP_MIN);

  typedef enum logic [1:0] {StIdle, StPlay, StDead} state_e;

  state_e     state_q;
  logic       space_q;
  logic [7:0] lfsr_q;
  logic [9:0] pipe_x_q  [2];
  logic [9:0] gap_y_q   [2];
  logic [1:0] scored_q;

  assign PipeX0 = pipe_x_q[0];
  assign PipeX1 = pipe_x_q[1];
  assign GapY0  = gap_y_q[0];
  assign GapY1  = gap_y_q[1];

  // ---------------------------------------------------------------------------
  // Input edge detect and gap generator
  // ---------------------------------------------------------------------------
  logic rise;
  assign rise = space & ~space_q;

  // x^8 + x^6 + x^5 + x^4 + 1, shifting toward the MSB
  logic       lfsr_fb;
  logic [7:0] lfsr_d;
  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign lfsr_d  = {lfsr_q[6:0], lfsr_fb};

  logic [9:0] new_gap;
  assign new_gap = GapMinW + {3'b000, lfsr_q[6:0]};

  // ---------------------------------------------------------------------------
  // Collision detection; 11-bit sums so nothing wraps at 1024
  // ---------------------------------------------------------------------------
  logic [10:0] bird_left;
  logic [10:0] bird_top;
  logic [10:0] bird_right;
  logic [10:0] bird_bot;
  logic        hit_ceiling;
  logic        hit_ground;
  logic [1:0]  hit_pipe;
  logic        crash;

  assign bird_left  = {1'b0, BirdX};
  assign bird_top   = {1'b0, BirdY};
  assign bird_right = {1'b0, BirdX} + {1'b0, BirdS};
  assign bird_bot   = {1'b0, BirdY} + {1'b0, BirdS};

  assign hit_ceiling = BirdY[9];
  assign hit_ground  = ~BirdY[9] && (bird_bot >= GroundW);

  logic [10:0] pipe_right [2];
  logic [10:0] gap_bot    [2];
  logic [1:0]  pass;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      pipe_right[i] = {1'b0, pipe_x_q[i]} + PipeWW;
      gap_bot[i]    = {1'b0, gap_y_q[i]} + GapHW;
      hit_pipe[i]   = (bird_right > {1'b0, pipe_x_q[i]}) && (bird_left < pipe_right[i]) &&
                      ((bird_top < {1'b0, gap_y_q[i]}) || (bird_bot > gap_bot[i]));
      // Bird left edge strictly past the pipe's right edge
      pass[i]       = ~scored_q[i] && (pipe_right[i] < bird_left);
    end
  end

  assign crash = hit_ceiling | hit_ground | (|hit_pipe);

  // ---------------------------------------------------------------------------
  // Scroll / respawn / score next-state for a non-crashing PLAY edge
  // ---------------------------------------------------------------------------
  logic [9:0] pipe_x_d [2];
  logic [9:0] gap_y_d  [2];
  logic [1:0] scored_d;
  logic [8:0] score_sum;
  logic [7:0] score_d;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      if (pipe_x_q[i] < StepW) begin
        // Pipe vanishes at the left edge and reappears at the right with a fresh gap
        pipe_x_d[i] = PipeX0Rst;
        gap_y_d[i]  = new_gap;
        scored_d[i] = 1'b0;
      end else begin
        pipe_x_d[i] = pipe_x_q[i] - StepW;
        gap_y_d[i]  = gap_y_q[i];
        scored_d[i] = scored_q[i] | pass[i];
      end
    end
    score_sum = {1'b0, Score} + {8'd0, pass[0]} + {8'd0, pass[1]};
    score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];
  end

  // ---------------------------------------------------------------------------
  // Game FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= StIdle;
      gameOn      <= 1'b0;
      ded         <= 1'b0;
      space_q     <= 1'b0;
      lfsr_q      <= LFSR_SEED;
      pipe_x_q[0] <= PipeX0Rst;
      pipe_x_q[1] <= PipeX1Rst;
      gap_y_q[0]  <= GapRst;
      gap_y_q[1]  <= GapRst;
      scored_q    <= 2'b00;
      Score       <= 8'd0;
    end else begin
      space_q <= space;
      lfsr_q  <= lfsr_d;
      case (state_q)
        StIdle: begin
          if (rise) begin
            state_q <= StPlay;
            gameOn  <= 1'b1;
          end
        end
        StPlay: begin
          if (crash) begin
            // Crash freezes the playfield exactly as it was on contact
            state_q <= StDead;
            gameOn  <= 1'b0;
            ded     <= 1'b1;
          end else begin
            for (int i = 0; i < 2; i++) begin
              pipe_x_q[i] <= pipe_x_d[i];
              gap_y_q[i]  <= gap_y_d[i];
            end
            scored_q <= scored_d;
            Score    <= score_d;
          end
        end
        StDead: begin
          if (rise) begin
            state_q     <= StIdle;
            ded         <= 1'b0;
            pipe_x_q[0] <= PipeX0Rst;
            pipe_x_q[1] <= PipeX1Rst;
            gap_y_q[0]  <= GapRst;
            gap_y_q[1]  <= GapRst;
            scored_q    <= 2'b00;
            Score       <= 8'd0;
          end
        end
        default: begin
          state_q <= StIdle;
          gameOn  <= 1'b0;
          ded     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Directed self-checking bench for flappy_game_ctrl.
module tb_flappy_game_ctrl;

  logic       Reset;
  logic       frame_clk;
  logic       space;
  logic [9:0] BirdX;
  logic [9:0] BirdY;
  logic [9:0] BirdS;
  logic       gameOn;
  logic       ded;
  logic [9:0] PipeX0;
  logic [9:0] PipeX1;
  logic [9:0] GapY0;
  logic [9:0] GapY1;
  logic [7:0] Score;

  flappy_game_ctrl dut (
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .space     (space),
    .BirdX     (BirdX),
    .BirdY     (BirdY),
    .BirdS     (BirdS),
    .gameOn    (gameOn),
    .ded       (ded),
    .PipeX0    (PipeX0),
    .PipeX1    (PipeX1),
    .GapY0     (GapY0),
    .GapY1     (GapY1),
    .Score     (Score)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Edges since the last reset, used to know how far the LFSR has advanced
  int edge_cnt;
  always @(posedge frame_clk or posedge Reset) begin
    if (Reset) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  function automatic logic [7:0] lfsr_at(input int n);
    logic [7:0] l;
    l = 8'hA5;
    for (int i = 0; i < n; i++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    return l;
  endfunction

  // {gameOn, ded, PipeX0, PipeX1, Score}
  logic [29:0] obs;
  assign obs = {gameOn, ded, PipeX0, PipeX1, Score};

  logic [29:0] exp_v;
  logic [9:0]  px0, px1, pb0, pb1;
  logic [7:0]  sc;

  task automatic tick;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    space = 1'b0;
    BirdX = 10'd100;
    BirdY = 10'd180;
    BirdS = 10'd16;
    #1;
    n_checks++;
    if (obs !== {1'b0, 1'b0, 10'd640, 10'd960, 8'd0} || GapY0 !== 10'd160 || GapY1 !== 10'd160)
      $display("FAIL reset_values: got %h gaps %0d/%0d required %h gaps 160/160",
               obs, GapY0, GapY1, {1'b0, 1'b0, 10'd640, 10'd960, 8'd0});
    else n_pass++;
    #21 Reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick;
      n_checks++;
      if (obs !== {1'b0, 1'b0, 10'd640, 10'd960, 8'd0})
        $display("FAIL idle_hold frame %0d: got %h required %h", k, obs,
                 {1'b0, 1'b0, 10'd640, 10'd960, 8'd0});
      else n_pass++;
    end
  endtask

  task automatic test_start;
    space = 1'b1;
    tick;
    n_checks++;
    if (obs !== {1'b1, 1'b0, 10'd640, 10'd960, 8'd0})
      $display("FAIL start_edge: got %h required %h", obs, {1'b1, 1'b0, 10'd640, 10'd960, 8'd0});
    else n_pass++;
    px0 = 10'd640;
    px1 = 10'd960;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) space = 1'b0;
      tick;
      px0 = px0 - 10'd2;
      px1 = px1 - 10'd2;
      exp_v = {1'b1, 1'b0, px0, px1, 8'd0};
      n_checks++;
      if (obs !== exp_v) $display("FAIL scroll_%0d: got %h required %h", k, obs, exp_v);
      else n_pass++;
    end
    n_checks++;
    if (PipeX0 !== 10'd630) $display("FAIL scroll_after_5: got %0d required 630", PipeX0);
    else n_pass++;
  endtask

  task automatic test_score_respawn;
    logic       passed;
    logic [7:0] l;
    logic [9:0] exp_gap;
    passed = 1'b0;
    sc     = 8'd0;
    for (int k = 0; k < 316; k++) begin
      pb0 = px0;
      pb1 = px1;
      px0 = (pb0 < 10'd2) ? 10'd640 : pb0 - 10'd2;
      px1 = (pb1 < 10'd2) ? 10'd640 : pb1 - 10'd2;
      if (!passed && (pb0 + 32 < 100)) begin
        passed = 1'b1;
        sc     = 8'd1;
      end
      tick;
      exp_v = {1'b1, 1'b0, px0, px1, sc};
      n_checks++;
      if (obs !== exp_v) $display("FAIL play_step (PipeX0 was %0d): got %h required %h",
                                  pb0, obs, exp_v);
      else n_pass++;
      if (pb0 == 10'd66) begin
        n_checks++;
        if (Score !== 8'd1) $display("FAIL score_at_66: got %0d required 1", Score);
        else n_pass++;
      end
      if (pb0 < 10'd2) begin
        l       = lfsr_at(edge_cnt - 1);
        exp_gap = 10'd96 + {3'b000, l[6:0]};
        n_checks++;
        if (GapY0 !== exp_gap) $display("FAIL respawn_gap: got %0d required %0d", GapY0, exp_gap);
        else n_pass++;
        n_checks++;
        if (GapY0 < 10'd96 || GapY0 > 10'd223)
          $display("FAIL respawn_gap_range: got %0d required 96..223", GapY0);
        else n_pass++;
        n_checks++;
        if (GapY1 !== 10'd160) $display("FAIL gap1_untouched: got %0d required 160", GapY1);
        else n_pass++;
      end
    end
  endtask

  task automatic test_ground_crash;
    BirdY = 10'd470;
    for (int k = 0; k < 4; k++) begin
      tick;
      exp_v = {1'b0, 1'b1, px0, px1, 8'd1};
      n_checks++;
      if (obs !== exp_v) $display("FAIL ground_dead_%0d: got %h required %h", k, obs, exp_v);
      else n_pass++;
    end
    BirdY = 10'd180;
    space = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick;
      exp_v = {1'b0, 1'b0, 10'd640, 10'd960, 8'd0};
      n_checks++;
      if (obs !== exp_v || GapY0 !== 10'd160 || GapY1 !== 10'd160)
        $display("FAIL dead_to_idle_%0d: got %h gaps %0d/%0d required %h gaps 160/160",
                 k, obs, GapY0, GapY1, exp_v);
      else n_pass++;
    end
    space = 1'b0;
    tick;
    space = 1'b1;
    tick;
    space = 1'b0;
    n_checks++;
    if (obs !== {1'b1, 1'b0, 10'd640, 10'd960, 8'd0})
      $display("FAIL restart: got %h required %h", obs, {1'b1, 1'b0, 10'd640, 10'd960, 8'd0});
    else n_pass++;
  endtask

  task automatic test_pipe_crash;
    BirdX = 10'd640;
    BirdY = 10'd100;
    for (int k = 0; k < 2; k++) begin
      tick;
      exp_v = {1'b0, 1'b1, 10'd640, 10'd960, 8'd0};
      n_checks++;
      if (obs !== exp_v) $display("FAIL pipe_crash_%0d: got %h required %h", k, obs, exp_v);
      else n_pass++;
    end
    BirdX = 10'd100;
    BirdY = 10'd180;
    space = 1'b1;
    tick;
    space = 1'b0;
    tick;
    space = 1'b1;
    tick;
    space = 1'b0;
  endtask

  task automatic test_ceiling_crash;
    BirdY = 10'h3F8;
    tick;
    exp_v = {1'b0, 1'b1, 10'd640, 10'd960, 8'd0};
    n_checks++;
    if (obs !== exp_v) $display("FAIL ceiling_crash: got %h required %h", obs, exp_v);
    else n_pass++;
    BirdY = 10'd180;
  endtask

  task automatic test_reset_mid;
    space = 1'b1;
    tick;
    space = 1'b0;
    tick;
    space = 1'b1;
    tick;
    space = 1'b0;
    for (int k = 0; k < 3; k++) tick;
    exp_v = {1'b1, 1'b0, 10'd634, 10'd954, 8'd0};
    n_checks++;
    if (obs !== exp_v) $display("FAIL pre_reset_play: got %h required %h", obs, exp_v);
    else n_pass++;
    #2 Reset = 1'b1;
    #1;
    exp_v = {1'b0, 1'b0, 10'd640, 10'd960, 8'd0};
    n_checks++;
    if (obs !== exp_v || GapY0 !== 10'd160 || GapY1 !== 10'd160)
      $display("FAIL async_reset: got %h gaps %0d/%0d required %h gaps 160/160",
               obs, GapY0, GapY1, exp_v);
    else n_pass++;
    #1 Reset = 1'b0;
    tick;
    n_checks++;
    if (obs !== exp_v) $display("FAIL post_reset_idle: got %h required %h", obs, exp_v);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_start;
    test_score_respawn;
    test_ground_crash;
    test_pipe_crash;
    test_ceiling_crash;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
